// File: rtl/posit_encode_pipe.sv
// Integer-to-posit back end: normalises a magnitude using its leading-one index, packs
// regime/exponent/fraction, rounds to nearest-even and applies sign over a 3-stage valid/ready pipe.
module posit_encode_pipe #(
    parameter int unsigned N  = 16,
    parameter int unsigned S  = $clog2(N),
    parameter int unsigned NP = 16,
    parameter int unsigned ES = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sign,
    input  logic [N-1:0]  in_mag,
    input  logic [S-1:0]  in_lod,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [NP-1:0] out_posit
);

    localparam int unsigned W    = NP + N + 2;
    localparam int unsigned KW   = S + 1;
    localparam int unsigned PADW = W - ES - (N - 1);

    logic          r_s1_v, r_s1_zero, r_s1_sign;
    logic [S-1:0]  r_s1_p;
    logic [N-2:0]  r_s1_frac;

    logic          r_s2_v, r_s2_zero, r_s2_sign, r_s2_sat, r_s2_guard, r_s2_sticky;
    logic [NP-2:0] r_s2_body;

    logic          r_s3_v;
    logic [NP-1:0] r_s3_posit;

    logic          w_s1_en, w_s2_en, w_s3_en;
    logic [S-1:0]  w_shift;
    logic [N-1:0]  w_norm;
    logic [KW-1:0] w_k;
    logic [ES-1:0] w_e;
    logic [W-1:0]  w_ones, w_tail, w_body;
    logic          w_sat, w_inc;
    logic [NP-1:0] w_sum, w_mag, w_posit;

    // A stage may load when it is empty or its contents move on this edge
    assign w_s3_en  = ~r_s3_v | out_ready;
    assign w_s2_en  = ~r_s2_v | w_s3_en;
    assign w_s1_en  = ~r_s1_v | w_s2_en;
    assign in_ready = w_s1_en;

    assign out_valid = r_s3_v;
    assign out_posit = r_s3_posit;

    // Stage 1: left-justify so the leading one sits at bit N-1, then drop it
    assign w_shift = S'(N - 1) - in_lod;
    assign w_norm  = in_mag << w_shift;

    // Stage 2: regime is k+1 ones and a terminating zero, followed by exponent and fraction
    assign w_k    = KW'(r_s1_p >> ES);
    assign w_e    = r_s1_p[ES-1:0];
    assign w_ones = ~({W{1'b1}} >> (w_k + KW'(1)));
    assign w_tail = {w_e, r_s1_frac, {PADW{1'b0}}} >> (w_k + KW'(2));
    assign w_body = w_ones | w_tail;
    assign w_sat  = (32'(w_k) + 32'(ES) + 32'd2) > 32'(NP - 1);

    // Stage 3: round-to-nearest-even; a carry out of the body means we passed maxpos
    assign w_inc   = r_s2_guard & (r_s2_body[0] | r_s2_sticky);
    assign w_sum   = {1'b0, r_s2_body} + NP'(w_inc);
    assign w_mag   = (r_s2_sat | w_sum[NP-1]) ? {1'b0, {(NP-1){1'b1}}} : w_sum;
    assign w_posit = r_s2_zero ? '0 : (r_s2_sign ? (~w_mag + NP'(1)) : w_mag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_v      <= 1'b0;
            r_s1_zero   <= 1'b0;
            r_s1_sign   <= 1'b0;
            r_s1_p      <= '0;
            r_s1_frac   <= '0;
            r_s2_v      <= 1'b0;
            r_s2_zero   <= 1'b0;
            r_s2_sign   <= 1'b0;
            r_s2_sat    <= 1'b0;
            r_s2_guard  <= 1'b0;
            r_s2_sticky <= 1'b0;
            r_s2_body   <= '0;
            r_s3_v      <= 1'b0;
            r_s3_posit  <= '0;
        end else begin
            if (w_s1_en) begin
                r_s1_v <= in_valid;
                if (in_valid) begin
                    r_s1_zero <= (in_mag == '0);
                    r_s1_sign <= in_sign;
                    r_s1_p    <= in_lod;
                    r_s1_frac <= w_norm[N-2:0];
                end
            end
            if (w_s2_en) begin
                r_s2_v <= r_s1_v;
                if (r_s1_v) begin
                    r_s2_zero   <= r_s1_zero;
                    r_s2_sign   <= r_s1_sign;
                    r_s2_sat    <= w_sat;
                    r_s2_body   <= w_body[W-1 -: NP-1];
                    r_s2_guard  <= w_body[W-NP];
                    r_s2_sticky <= |w_body[W-NP-1:0];
                end
            end
            if (w_s3_en) begin
                r_s3_v <= r_s2_v;
                if (r_s2_v) begin
                    r_s3_posit <= w_posit;
                end
            end
        end
    end

endmodule
